// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, functs, FSM state encodings and ALU control codes for the multi-cycle CPU
package cpu_pkg;
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  typedef enum logic [3:0] {
    S0 = 4'd0, S1 = 4'd1, S2 = 4'd2, S3 = 4'd3, S4 = 4'd4,
    S5 = 4'd5, S6 = 4'd6, S7 = 4'd7, S8 = 4'd8, S9 = 4'd9
  } state_t;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3, ALU_SLT = 3'd4
  } alu_ctl_t;
  function automatic logic funct_ok(input logic [5:0] f);
    return f == FN_ADD || f == FN_SUB || f == FN_AND || f == FN_OR || f == FN_SLT;
  endfunction
  function automatic alu_ctl_t alu_dec(input logic [5:0] f);
    return f == FN_SUB ? ALU_SUB : f == FN_AND ? ALU_AND : f == FN_OR ? ALU_OR :
           f == FN_SLT ? ALU_SLT : ALU_ADD;
  endfunction
endpackage

// File: rtl/cpu_logic_cu.sv
// cu_logic: multi-cycle control FSM plus ALU-control decoder
// inputs : clk, rst_n, op[5:0], funct[5:0] (from IR)
// outputs: datapath strobes (pc_write, pc_write_cond, i_or_d, mem_write, ir_write, mem_to_reg, reg_dst,
//          reg_write, alu_src_a, alu_src_b[1:0], pc_source[1:0]), register loads (ab_write,
//          alu_out_write, mdr_write) and alu_ctl[2:0]
module cu_logic import cpu_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic       ab_write,
  output logic       alu_out_write,
  output logic       mdr_write,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] alu_ctl
);
  state_t S, s_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) S <= S0;
    else S <= s_d;
  // unknown opcodes and unknown R-type functs fall back to fetch straight after decode
  always_comb begin
    s_d = S0;
    case (S)
      S0: s_d = S1;
      S1: s_d = (op == OP_LW || op == OP_SW) ? S2 :
                (op == OP_R && funct_ok(funct)) ? S6 :
                op == OP_BEQ ? S8 : op == OP_J ? S9 : S0;
      S2: s_d = op == OP_LW ? S3 : S5;
      S3: s_d = S4;
      S6: s_d = S7;
      default: s_d = S0;
    endcase
  end
  always_comb begin
    pc_write = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    ab_write = 1'b0;
    alu_out_write = 1'b0;
    mdr_write = 1'b0;
    alu_src_b = 2'd0;
    pc_source = 2'd0;
    alu_ctl = ALU_ADD;
    case (S)
      S0: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        alu_src_b = 2'd1;
      end
      S1: begin
        ab_write = 1'b1;
        alu_out_write = 1'b1;
        alu_src_b = 2'd3;
      end
      S2: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_out_write = 1'b1;
      end
      S3: begin
        i_or_d = 1'b1;
        mdr_write = 1'b1;
      end
      S4: begin
        reg_write = 1'b1;
        mem_to_reg = 1'b1;
      end
      S5: begin
        i_or_d = 1'b1;
        mem_write = 1'b1;
      end
      S6: begin
        alu_src_a = 1'b1;
        alu_out_write = 1'b1;
        alu_ctl = alu_dec(funct);
      end
      S7: begin
        reg_write = 1'b1;
        reg_dst = 1'b1;
      end
      S8: begin
        alu_src_a = 1'b1;
        pc_write_cond = 1'b1;
        pc_source = 2'd1;
        alu_ctl = ALU_SUB;
      end
      S9: begin
        pc_write = 1'b1;
        pc_source = 2'd2;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/cpu_logic_dp.sv
// cpu_logic_dp: datapath building blocks (enable register, register file, unified memory, ALU)
// enreg   : clk, rst_n, en, d[31:0] -> q[31:0]; async active-low reset to RST
// regfile : clk, we, ra1/ra2/wa[4:0], wd[31:0] -> rd1/rd2[31:0]; $0 reads 0 and ignores writes
// cpu_mem : clk, we, addr[31:0], wdata[31:0] -> rdata[31:0]; big-endian bytes, address wraps
// alu     : ctl[2:0], a/b[31:0] -> y[31:0], zero
module enreg #(
  parameter logic [31:0] RST = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] q
);
  logic [31:0] Q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) Q <= RST;
    else if (en) Q <= d;
  assign q = Q;
endmodule

module regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] RF [0:31];
  assign rd1 = ra1 == 5'd0 ? 32'd0 : RF[ra1];
  assign rd2 = ra2 == 5'd0 ? 32'd0 : RF[ra2];
  always_ff @(posedge clk)
    if (we && wa != 5'd0) RF[wa] <= wd;
endmodule

module cpu_mem #(
  parameter int MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  localparam int AW = $clog2(MEM_BYTES);
  logic [7:0] data [0:MEM_BYTES-1];
  logic [AW-1:0] i0, i1, i2, i3;
  // byte lanes of a word wrap independently at the top of memory
  assign i0 = AW'(addr % MEM_BYTES);
  assign i1 = i0 + AW'(1);
  assign i2 = i0 + AW'(2);
  assign i3 = i0 + AW'(3);
  assign rdata = {data[i0], data[i1], data[i2], data[i3]};
  always_ff @(posedge clk)
    if (we) begin
      data[i0] <= wdata[31:24];
      data[i1] <= wdata[23:16];
      data[i2] <= wdata[15:8];
      data[i3] <= wdata[7:0];
    end
endmodule

module alu import cpu_pkg::*; (
  input  logic [2:0]  ctl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        zero
);
  always_comb begin
    y = ctl == ALU_SUB ? a - b :
        ctl == ALU_AND ? a & b :
        ctl == ALU_OR  ? a | b :
        ctl == ALU_SLT ? {31'd0, $signed(a) < $signed(b)} : a + b;
    zero = y == 32'd0;
  end
endmodule

// File: rtl/cpu_logic.sv
// cpu_logic: multi-cycle 32-bit MIPS-subset CPU with one unified byte-addressed memory
// ports: clk (rising-edge), rst_n (async active-low); all other stimulus is preloaded hierarchically
module cpu_logic import cpu_pkg::*; #(
  parameter int          MEM_BYTES = 256,
  parameter logic [31:0] PC_RESET  = 32'd0
) (
  input logic clk,
  input logic rst_n
);
  logic pc_write, pc_write_cond, i_or_d, mem_write, ir_write, mem_to_reg, reg_dst, reg_write;
  logic alu_src_a, ab_write, alu_out_write, mdr_write, alu_zero, pc_en;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_ctl;
  logic [4:0] rf_wa;
  logic [31:0] pc, ir, mdr, a, b, alu_out, mem_addr, mem_rdata, rf_rd1, rf_rd2, rf_wd;
  logic [31:0] sext, src_a, src_b, alu_y, pc_next;
  always_comb begin
    sext = {{16{ir[15]}}, ir[15:0]};
    mem_addr = i_or_d ? alu_out : pc;
    rf_wa = reg_dst ? ir[15:11] : ir[20:16];
    rf_wd = mem_to_reg ? mdr : alu_out;
    src_a = alu_src_a ? a : pc;
    src_b = alu_src_b == 2'd0 ? b : alu_src_b == 2'd1 ? 32'd4 :
            alu_src_b == 2'd2 ? sext : {sext[29:0], 2'b00};
    pc_next = pc_source == 2'd0 ? alu_y : pc_source == 2'd1 ? alu_out :
              {pc[31:28], ir[25:0], 2'b00};
    pc_en = pc_write | (pc_write_cond & alu_zero);
  end
  enreg #(.RST(PC_RESET)) PC (.clk(clk), .rst_n(rst_n), .en(pc_en), .d(pc_next), .q(pc));
  enreg ir_reg (.clk(clk), .rst_n(rst_n), .en(ir_write), .d(mem_rdata), .q(ir));
  enreg mdr_reg (.clk(clk), .rst_n(rst_n), .en(mdr_write), .d(mem_rdata), .q(mdr));
  enreg a_reg (.clk(clk), .rst_n(rst_n), .en(ab_write), .d(rf_rd1), .q(a));
  enreg b_reg (.clk(clk), .rst_n(rst_n), .en(ab_write), .d(rf_rd2), .q(b));
  enreg alu_out_reg (.clk(clk), .rst_n(rst_n), .en(alu_out_write), .d(alu_y), .q(alu_out));
  regfile RegFile (
    .clk(clk), .we(reg_write), .ra1(ir[25:21]), .ra2(ir[20:16]), .wa(rf_wa), .wd(rf_wd),
    .rd1(rf_rd1), .rd2(rf_rd2)
  );
  cpu_mem #(.MEM_BYTES(MEM_BYTES)) mem (
    .clk(clk), .we(mem_write), .addr(mem_addr), .wdata(b), .rdata(mem_rdata)
  );
  alu u_alu (.ctl(alu_ctl), .a(src_a), .b(src_b), .y(alu_y), .zero(alu_zero));
  cu_logic CU (
    .clk(clk), .rst_n(rst_n), .op(ir[31:26]), .funct(ir[5:0]),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .ab_write(ab_write), .alu_out_write(alu_out_write),
    .mdr_write(mdr_write), .alu_src_b(alu_src_b), .pc_source(pc_source), .alu_ctl(alu_ctl)
  );
endmodule

// File: tb/tb_cpu_logic.sv
// tb_cpu_logic: directed and random-program checks of cpu_logic against an instruction-level model
module tb_cpu_logic;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_rf [32];
  logic [7:0]  m_mem [256];
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  cpu_logic dut (.clk(clk), .rst_n(rst_n));

  function automatic logic [31:0] m_word(input logic [31:0] a);
    logic [7:0] p;
    p = a[7:0];
    return {m_mem[p], m_mem[p + 8'd1], m_mem[p + 8'd2], m_mem[p + 8'd3]};
  endfunction

  function automatic void m_wr(input logic [31:0] a, input logic [31:0] v);
    logic [7:0] p;
    p = a[7:0];
    m_mem[p] = v[31:24];
    m_mem[p + 8'd1] = v[23:16];
    m_mem[p + 8'd2] = v[15:8];
    m_mem[p + 8'd3] = v[7:0];
  endfunction

  // executes one instruction on the architectural model; returns its cycle count
  function automatic int m_step();
    logic [31:0] ins, a, b, imm, res;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    ins = m_word(m_pc);
    m_pc = m_pc + 32'd4;
    op = ins[31:26];
    rs = ins[25:21];
    rt = ins[20:16];
    rd = ins[15:11];
    fn = ins[5:0];
    imm = {{16{ins[15]}}, ins[15:0]};
    a = m_rf[rs];
    b = m_rf[rt];
    if (op == 6'b000000) begin
      case (fn)
        6'b100000: res = a + b;
        6'b100010: res = a - b;
        6'b100100: res = a & b;
        6'b100101: res = a | b;
        6'b101010: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: return 2;
      endcase
      if (rd != 5'd0) m_rf[rd] = res;
      return 4;
    end
    if (op == 6'b100011) begin
      if (rt != 5'd0) m_rf[rt] = m_word(a + imm);
      return 5;
    end
    if (op == 6'b101011) begin
      m_wr(a + imm, b);
      return 4;
    end
    if (op == 6'b000100) begin
      if (a == b) m_pc = m_pc + (imm << 2);
      return 3;
    end
    if (op == 6'b000010) begin
      m_pc = {m_pc[31:28], ins[25:0], 2'b00};
      return 3;
    end
    return 2;
  endfunction

  function automatic logic [31:0] gen_ins();
    int r;
    logic [5:0] fns [5];
    logic [4:0] rs, rt, rd;
    logic [15:0] imm;
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    r = $urandom_range(0, 99);
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    imm = 16'($urandom_range(0, 255) - 128);
    if (r < 30) return {6'b000000, rs, rt, rd, 5'd0, fns[$urandom_range(0, 4)]};
    if (r < 34) return {6'b000000, rs, rt, rd, 5'd0, 6'b000111};
    if (r < 48) return {6'b100011, rs, rt, imm};
    if (r < 62) return {6'b101011, rs, rt, imm};
    if (r < 76) return {6'b000100, 5'($urandom_range(0, 2)), 5'($urandom_range(0, 2)),
                        16'($urandom_range(0, 6) - 3)};
    if (r < 86) return {6'b000010, 26'($urandom_range(0, 15))};
    return {6'b001000, rs, rt, imm};
  endfunction

  task automatic start();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      m_rf[i] = 32'd0;
      dut.RegFile.RF[i] = 32'd0;
    end
    for (int i = 0; i < 256; i++) begin
      m_mem[i] = 8'd0;
      dut.mem.data[i] = 8'd0;
    end
    m_pc = 32'd0;
  endtask

  task automatic set_reg(input int r, input logic [31:0] v);
    m_rf[r] = v;
    dut.RegFile.RF[r] = v;
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    logic [7:0] p;
    for (int k = 0; k < 4; k++) begin
      p = 8'(a + 32'(k));
      m_mem[p] = w[31 - 8 * k -: 8];
      dut.mem.data[p] = w[31 - 8 * k -: 8];
    end
  endtask

  task automatic go();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] got [7];
    start();
    got = '{dut.PC.Q, 32'(dut.CU.S), dut.ir_reg.Q, dut.mdr_reg.Q, dut.a_reg.Q, dut.b_reg.Q,
            dut.alu_out_reg.Q};
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (got[i] !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_state[%0d]: got %h expected 00000000", i, got[i]);
      end
    end
  endtask

  task automatic test_lw();
    start();
    set_reg(1, 32'd2);
    set_word(0, 32'h8C240002);
    set_word(4, 32'hDEADBEEF);
    go();
    repeat (5) @(negedge clk);
    vectors++;
    if (dut.RegFile.RF[4] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL lw_rf4: got %h expected deadbeef", dut.RegFile.RF[4]);
    end
    vectors++;
    if (dut.PC.Q !== 32'd4) begin
      miscompares++;
      $display("FAIL lw_pc: got %h expected 00000004", dut.PC.Q);
    end
    vectors++;
    if (dut.CU.S !== 4'd0) begin
      miscompares++;
      $display("FAIL lw_state: got %0d expected 0", dut.CU.S);
    end
  endtask

  task automatic test_rtype();
    start();
    set_reg(1, 32'd5);
    set_reg(2, 32'd3);
    set_word(0, 32'h00221820);
    set_word(4, 32'h00222022);
    go();
    repeat (4) @(negedge clk);
    vectors++;
    if (dut.RegFile.RF[3] !== 32'd8) begin
      miscompares++;
      $display("FAIL add_rf3: got %h expected 00000008", dut.RegFile.RF[3]);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (dut.RegFile.RF[4] !== 32'd2) begin
      miscompares++;
      $display("FAIL sub_rf4: got %h expected 00000002", dut.RegFile.RF[4]);
    end
  endtask

  task automatic test_sw();
    logic [31:0] got;
    start();
    set_reg(1, 32'h10);
    set_reg(2, 32'h12345678);
    set_word(0, 32'hAC220000);
    go();
    repeat (4) @(negedge clk);
    got = {dut.mem.data[16], dut.mem.data[17], dut.mem.data[18], dut.mem.data[19]};
    vectors++;
    if (got !== 32'h12345678) begin
      miscompares++;
      $display("FAIL sw_mem: got %h expected 12345678", got);
    end
  endtask

  task automatic test_beq();
    for (int t = 0; t < 2; t++) begin
      start();
      set_reg(1, 32'd7);
      set_reg(2, t == 0 ? 32'd7 : 32'd8);
      set_word(0, 32'h10220002);
      go();
      repeat (3) @(negedge clk);
      vectors++;
      if (dut.PC.Q !== (t == 0 ? 32'h0C : 32'h04)) begin
        miscompares++;
        $display("FAIL beq_pc[%0d]: got %h expected %h", t, dut.PC.Q, t == 0 ? 32'h0C : 32'h04);
      end
    end
  endtask

  task automatic test_jump_zero();
    start();
    set_word(0, 32'h08000004);
    go();
    repeat (3) @(negedge clk);
    vectors++;
    if (dut.PC.Q !== 32'h10) begin
      miscompares++;
      $display("FAIL j_pc: got %h expected 00000010", dut.PC.Q);
    end
    start();
    set_reg(1, 32'd9);
    set_word(0, 32'h00210020);
    go();
    repeat (4) @(negedge clk);
    vectors++;
    if (dut.RegFile.RF[0] !== 32'd0) begin
      miscompares++;
      $display("FAIL zero_reg: got %h expected 00000000", dut.RegFile.RF[0]);
    end
  endtask

  task automatic test_reset_mid();
    start();
    set_reg(1, 32'd2);
    set_reg(4, 32'h11111111);
    set_word(0, 32'h8C240002);
    set_word(4, 32'hDEADBEEF);
    go();
    repeat (3) @(negedge clk);
    vectors++;
    if (dut.CU.S !== 4'd3) begin
      miscompares++;
      $display("FAIL mid_state_before: got %0d expected 3", dut.CU.S);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (dut.PC.Q !== 32'd0) begin
      miscompares++;
      $display("FAIL mid_async_pc: got %h expected 00000000", dut.PC.Q);
    end
    vectors++;
    if (dut.CU.S !== 4'd0) begin
      miscompares++;
      $display("FAIL mid_async_state: got %0d expected 0", dut.CU.S);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (dut.RegFile.RF[4] !== 32'h11111111) begin
      miscompares++;
      $display("FAIL mid_rf4: got %h expected 11111111", dut.RegFile.RF[4]);
    end
  endtask

  task automatic test_random();
    int cyc;
    logic [7:0] b;
    for (int p = 0; p < 20; p++) begin
      start();
      for (int i = 1; i < 32; i++) set_reg(i, $urandom);
      for (int i = 0; i < 256; i++) begin
        b = 8'($urandom);
        m_mem[i] = b;
        dut.mem.data[i] = b;
      end
      for (int i = 0; i < 16; i++) set_word(32'(4 * i), gen_ins());
      go();
      for (int k = 0; k < 40; k++) begin
        cyc = m_step();
        repeat (cyc) @(negedge clk);
        vectors++;
        if (dut.PC.Q !== m_pc || dut.CU.S !== 4'd0) begin
          miscompares++;
          $display("FAIL rand_pc[%0d.%0d]: got pc %h state %0d expected pc %h state 0",
                   p, k, dut.PC.Q, dut.CU.S, m_pc);
        end
      end
      for (int i = 0; i < 32; i++) begin
        vectors++;
        if (dut.RegFile.RF[i] !== m_rf[i]) begin
          miscompares++;
          $display("FAIL rand_rf[%0d.%0d]: got %h expected %h", p, i, dut.RegFile.RF[i], m_rf[i]);
        end
      end
      for (int i = 0; i < 256; i++) begin
        vectors++;
        if (dut.mem.data[i] !== m_mem[i]) begin
          miscompares++;
          $display("FAIL rand_mem[%0d.%0d]: got %h expected %h", p, i, dut.mem.data[i], m_mem[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_sw();
    test_beq();
    test_jump_zero();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
